// File: rtl/apb_spi_master.sv
// APB-programmable SPI master: three-phase serial engine (IDLE/LEAD/TRAIL) with a
// configurable clock divider, bit order, clock polarity/phase and chip-select control.
module apb_spi_master #(
  parameter int DATA_W = 32,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              cpu_reset_n,
  input  logic [7:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    TRAIL = 2'd2
  } state_e;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h04;
  localparam logic [7:0] ADDR_DIV    = 8'h08;
  localparam logic [7:0] ADDR_CS     = 8'h0C;
  localparam logic [7:0] ADDR_STATUS = 8'h10;
  localparam logic [6:0] DW          = 7'(DATA_W);

  state_e              state_q, state_d;
  logic [10:0]         ctrl_q, ctrl_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [NUM_CS-1:0]   cs_q, cs_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [6:0]          bitIdx_q, bitIdx_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                started_q, started_d;

  logic                wrEn, wrData, wrCtrl, wrDiv, wrCs, wrStatus;
  logic                busy, start, phaseEnd, lastBit, sampleNow;
  logic                cpol, cpha, lsbFirst, autoCs, irqEn;
  logic [6:0]          nEff, curPos, nxtPos, firstPos;
  logic [DATA_W-1:0]   txShift, loadShift;

  assign wrEn     = PSEL & PENABLE & PWRITE;
  assign wrData   = wrEn & (PADDR == ADDR_DATA);
  assign wrCtrl   = wrEn & (PADDR == ADDR_CTRL);
  assign wrDiv    = wrEn & (PADDR == ADDR_DIV);
  assign wrCs     = wrEn & (PADDR == ADDR_CS);
  assign wrStatus = wrEn & (PADDR == ADDR_STATUS);

  assign cpol     = ctrl_q[6];
  assign cpha     = ctrl_q[7];
  assign lsbFirst = ctrl_q[8];
  assign autoCs   = ctrl_q[9];
  assign irqEn    = ctrl_q[10];

  assign busy     = (state_q != IDLE);
  assign start    = wrData & ~busy;
  assign phaseEnd = (cnt_q == div_q);

  // Bit positions are derived from a transfer-order index so one counter serves both bit orders.
  always_comb begin
    nEff      = ((ctrl_q[5:0] == 6'd0) || ({1'b0, ctrl_q[5:0]} > DW)) ? DW : {1'b0, ctrl_q[5:0]};
    curPos    = lsbFirst ? bitIdx_q : (nEff - 7'd1 - bitIdx_q);
    nxtPos    = lsbFirst ? (bitIdx_q + 7'd1) : (nEff - 7'd2 - bitIdx_q);
    firstPos  = lsbFirst ? 7'd0 : (nEff - 7'd1);
    lastBit   = (bitIdx_q == (nEff - 7'd1));
    txShift   = tx_q >> nxtPos;
    loadShift = PWDATA[DATA_W-1:0] >> firstPos;
    sampleNow = (cnt_q == '0) && (state_q == (cpha ? TRAIL : LEAD));
  end

  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LEAD;
      LEAD:    if (phaseEnd) state_d = TRAIL;
      TRAIL:   if (phaseEnd) state_d = lastBit ? IDLE : LEAD;
      default: state_d = IDLE;
    endcase
  end

  // Serial outputs stay quiet after reset until the first transfer has been launched.
  always_comb begin
    spi_sclk = 1'b0;
    if (started_q) spi_sclk = (state_q == LEAD) ? ~cpol : cpol;
    spi_cs_n = '1;
    if (started_q && (!autoCs || busy)) spi_cs_n = ~cs_q;
  end

  assign spi_mosi = mosi_q;
  assign irq      = done_q & irqEn;
  assign PREADY   = 1'b1;

  always_comb begin
    ctrl_d    = ctrl_q;
    div_d     = div_q;
    cs_d      = cs_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = '0;
    bitIdx_d  = bitIdx_q;
    mosi_d    = mosi_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    started_d = started_q;

    if (wrCs) cs_d = PWDATA[NUM_CS-1:0];
    if (wrStatus && PWDATA[2]) ovr_d = 1'b0;
    if (wrStatus && PWDATA[1]) done_d = 1'b0;

    if (busy) begin
      if (wrData || wrCtrl || wrDiv) ovr_d = 1'b1;
      cnt_d = phaseEnd ? '0 : (cnt_q + DIV_W'(1));
    end else begin
      if (wrCtrl) ctrl_d = PWDATA[10:0];
      if (wrDiv) div_d = PWDATA[DIV_W-1:0];
    end

    if (start) begin
      tx_d      = PWDATA[DATA_W-1:0];
      rx_d      = '0;
      bitIdx_d  = '0;
      mosi_d    = loadShift[0];
      started_d = 1'b1;
    end

    if (sampleNow) rx_d = rx_q | ({{(DATA_W-1){1'b0}}, spi_miso} << curPos);

    if ((state_q == LEAD) && phaseEnd && !cpha && !lastBit) mosi_d = txShift[0];

    if ((state_q == TRAIL) && phaseEnd) begin
      if (lastBit) begin
        done_d = 1'b1;
      end else begin
        bitIdx_d = bitIdx_q + 7'd1;
        if (cpha) mosi_d = txShift[0];
      end
    end
  end

  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      ctrl_q    <= '0;
      div_q     <= '0;
      cs_q      <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      bitIdx_q  <= '0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      cs_q      <= cs_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      bitIdx_q  <= bitIdx_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    PRDATA = 32'hFFFF_FFFF;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        ADDR_DATA:   PRDATA = 32'(rx_q);
        ADDR_CTRL:   PRDATA = 32'(ctrl_q);
        ADDR_DIV:    PRDATA = 32'(div_q);
        ADDR_CS:     PRDATA = 32'(cs_q);
        ADDR_STATUS: PRDATA = {29'd0, ovr_q, done_q, busy};
        default:     PRDATA = 32'hFFFF_FFFF;
      endcase
    end
  end

endmodule

// File: doc/apb_spi_master.md
APB_SPI_MASTER -- requirements
Module: apb_spi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, maximum shift-register width in bits (range 8..32).
REQ-002 SHALL have parameter NUM_CS, default 4, number of chip-select outputs (1..8).
REQ-003 SHALL have parameter DIV_W, default 16, width of the SCLK divider register.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port cpu_reset_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports PADDR input 8, PSEL input 1, PENABLE input 1, PWRITE input 1, PWDATA input 32; together these form the APB slave request.
REQ-007 SHALL have ports PRDATA output 32 and PREADY output 1; together these form the APB slave response.
REQ-008 SHALL have port spi_sclk, output, 1, serial clock.
REQ-009 SHALL have port spi_mosi, output, 1, serial data out.
REQ-010 SHALL have port spi_miso, input, 1, serial data in.
REQ-011 SHALL have port spi_cs_n, output, NUM_CS, active-low chip selects.
REQ-012 SHALL have port irq, output, 1, transfer-complete interrupt, level.

Function
REQ-013 SHALL tie PREADY to 1 (no wait states); a write is applied on the cycle PSEL & PENABLE & PWRITE is high.
REQ-014 SHALL decode registers as follows:
- 0x00 DATA: write = TX word; read = RX word.
- 0x04 CTRL: [5:0] LEN, [6] CPOL, [7] CPHA, [8] LSB_FIRST, [9] AUTO_CS, [10] IRQ_EN.
- 0x08 DIV: [DIV_W-1:0].
- 0x0C CS: [NUM_CS-1:0] select mask.
- 0x10 STATUS: [0] BUSY, [1] DONE, [2] OVERRUN.
REQ-015 SHALL return PRDATA combinationally from PADDR when PSEL & !PWRITE; unmapped or non-selected reads return 0xFFFFFFFF; unused register bits read 0.
REQ-016 SHALL treat effective length N as follows: LEN=0 or LEN>DATA_W -> N=DATA_W; otherwise N=LEN.
REQ-017 SHALL start a transfer on a write to DATA while IDLE: load the TX shift register, clear RX, set BUSY on the next edge.
REQ-018 SHALL ignore writes to DATA, CTRL and DIV while BUSY and set OVERRUN sticky; writes to CS are always accepted.
REQ-019 SHALL use states IDLE, LEAD, TRAIL with these transitions:
- IDLE->LEAD on start.
- LEAD->TRAIL after DIV+1 clocks.
- TRAIL->LEAD after DIV+1 clocks if bits remain; else TRAIL->IDLE.
REQ-020 SHALL hold spi_sclk = CPOL in IDLE; spi_sclk = !CPOL in LEAD and CPOL in TRAIL.
REQ-021 SHALL make a transfer take exactly 2*N*(DIV+1) clocks with BUSY high; DIV=0 gives SCLK = clk/2.
REQ-022 SHALL, for CPHA=0, drive the first bit on spi_mosi at start, sample spi_miso at entry to LEAD, and shift the next bit out at entry to TRAIL.
REQ-023 SHALL, for CPHA=1, shift out a bit at entry to LEAD and sample spi_miso at entry to TRAIL.
REQ-024 SHALL send MSB first (bit N-1) when LSB_FIRST=0 and bit 0 first when LSB_FIRST=1; RX is assembled in the same order and right-justified in bits [N-1:0].
REQ-025 SHALL drive spi_cs_n = ~CS mask when AUTO_CS=0; when AUTO_CS=1, spi_cs_n = ~CS mask only while BUSY, otherwise all ones.
REQ-026 SHALL set DONE on the edge BUSY falls; DONE and OVERRUN are cleared by writing 1 to their STATUS bits.
REQ-027 SHALL give priority to setting DONE over a clear issued in the same cycle.
REQ-028 SHALL drive irq = DONE & IRQ_EN.
REQ-029 SHALL hold spi_mosi at its last value when IDLE.

Reset
REQ-030 SHALL, on cpu_reset_n low at any time including mid-transfer, immediately enter IDLE and clear all registers to 0.
REQ-031 SHALL, during and after reset, drive spi_sclk=0, spi_mosi=0, spi_cs_n all ones, irq=0 and BUSY=0 until the first post-reset DATA write.

Verification
REQ-032 SHALL cover mode 0 (CTRL=0x008, LEN=8, DIV=1, CS=0x1), writing DATA=0xA5 with MISO looping back MOSI -> MOSI shows 1,0,1,0,0,1,0,1; BUSY lasts 32 clocks; RX=0xA5; DONE=1; spi_cs_n=0xE.
REQ-033 SHALL cover mode 3 with LSB_FIRST (CPOL=1, CPHA=1, LEN=16, DIV=0) and DATA=0x1234 with MISO tied 1 -> idle SCLK=1; BUSY lasts 32 clocks; MOSI bit0 first; RX=0xFFFF.
REQ-034 SHALL cover a DATA write and a DIV write during BUSY -> both are ignored; OVERRUN=1; the original transfer completes unchanged.
REQ-035 SHALL cover AUTO_CS=1, CS=0x4, LEN=0, IRQ_EN=1 -> spi_cs_n=0xB only while BUSY; transfer is 32 bits; irq rises with DONE; writing 0x2 to STATUS drops irq.
REQ-036 SHALL cover cpu_reset_n pulsed low mid-transfer -> same cycle: SCLK=0, cs_n all ones, BUSY=0; no DONE set afterwards.
REQ-037 SHALL cover a read of 0x14 -> PRDATA=0xFFFFFFFF.
